instr_sequencer: RTL

Fetch/decode/dispatch controller sitting above the control unit. It reads 16-bit instructions from the ROM, splits them into opcode/dest/src, and presents them to the control unit until `exec_done` is seen. It then returns the control unit to its idle state by driving opcode `0000` for one cycle and advances the program counter. It handles NOP, JMP and HALT locally, so the control unit only ever sees data-path opcodes.

---
 rtl/instr_sequencer.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
//   Fetch/decode/dispatch controller that sits above the control unit.
//   It fetches 16-bit instructions from a synchronous ROM, handles NOP, JMP
//   and HALT itself, and presents data-path opcodes to the control unit
//   until exec_done. After every dispatched or NOP instruction it drives one
//   opcode=0000 cycle so the control unit returns to idle, and advances pc.
//
//   Optional feature macro: SEQ_WATCHDOG_EN
//     When defined, an EXEC that lasts WDT_CYCLES cycles without exec_done
//     is aborted: one opcode=0000 cycle, then HALT with fault=1. pc keeps
//     the address of the faulting instruction.
//
//   Ports
//     clk, rst_n        clock (rising edge), async active-low reset
//     run               level, free-run instructions
//     step              one-cycle pulse, single instruction from IDLE
//     rom_address       ROM address (= pc)
//     rom_read_enable   ROM read strobe, high in FETCH
//     rom_data          ROM data, valid one cycle after the strobe
//     opcode/dest/src   instruction fields to the control unit
//     exec_done         control unit finished the current opcode
//     pc                program counter
//     busy              high in every state except IDLE and HALT
//     halted            high in HALT
//     fault             watchdog abort flag (0 without SEQ_WATCHDOG_EN)
//
//   state  | meaning
//   IDLE   | waiting for run or a step pulse
//   FETCH  | ROM strobe with address = pc
//   WAIT   | ROM access latency
//   DECODE | capture rom_data into ir and branch on opcode
//   EXEC   | opcode/dest/src presented until exec_done
//   CLEAR  | opcode=0000 for one cycle, pc+1
//   HALT   | terminal, left only by reset
//   ABORT  | watchdog: opcode=0000 for one cycle, pc held, then HALT
// ---------------------------------------------------------------------------
module instr_sequencer #(
    parameter int PC_W       = 8,
    parameter int WDT_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    input  logic            step,
    output logic [PC_W-1:0] rom_address,
    output logic            rom_read_enable,
    input  logic [15:0]     rom_data,
    output logic [3:0]      opcode,
    output logic [5:0]      dest,
    output logic [5:0]      src,
    input  logic            exec_done,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            halted,
    output logic            fault
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WAIT, S_DECODE, S_EXEC, S_CLEAR, S_HALT, S_ABORT
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_RSVD = 4'b1110;
    localparam logic [3:0] OP_JMP  = 4'b1101;
    localparam logic [3:0] OP_HALT = 4'b1111;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     ir_q, ir_d;
    logic            step_req_q, step_req_d;
    logic [3:0]      opcode_q, opcode_d;
    logic            rre_q, rre_d;
    logic            busy_q, busy_d;
    logic            halted_q, halted_d;
    state_t          cont_state;

`ifdef SEQ_WATCHDOG_EN
    localparam int WDT_W = $clog2(WDT_CYCLES + 1);
    logic [WDT_W-1:0] wdt_q, wdt_d;
    logic             fault_q, fault_d;
`endif

    // Where to go after an instruction retires: keep running only in
    // free-run mode; a step request always ends in IDLE.
    assign cont_state = (run && !step_req_q) ? S_FETCH : S_IDLE;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        step_req_d = step_req_q;
`ifdef SEQ_WATCHDOG_EN
        wdt_d      = wdt_q;
        fault_d    = fault_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d    = S_FETCH;
                    step_req_d = 1'b0;
                end else if (step) begin
                    state_d    = S_FETCH;
                    step_req_d = 1'b1;
                end
            end
            S_FETCH:  state_d = S_WAIT;
            S_WAIT:   state_d = S_DECODE;
            S_DECODE: begin
                ir_d = rom_data;
`ifdef SEQ_WATCHDOG_EN
                wdt_d = '0;
`endif
                unique case (rom_data[15:12])
                    OP_NOP, OP_RSVD: state_d = S_CLEAR;
                    OP_JMP: begin
                        pc_d    = rom_data[PC_W-1:0];
                        state_d = cont_state;
                    end
                    OP_HALT: state_d = S_HALT;
                    default: state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                if (exec_done) begin
                    state_d = S_CLEAR;
                end
`ifdef SEQ_WATCHDOG_EN
                // exec_done has priority over the limit in the same cycle
                else if (wdt_q == WDT_W'(WDT_CYCLES - 1)) begin
                    state_d = S_ABORT;
                end else begin
                    wdt_d = wdt_q + WDT_W'(1);
                end
`endif
            end
            S_CLEAR: begin
                pc_d    = pc_q + PC_W'(1);
                state_d = cont_state;
            end
            S_ABORT: begin
                state_d = S_HALT;
`ifdef SEQ_WATCHDOG_EN
                fault_d = 1'b1;
`endif
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_IDLE) begin
            step_req_d = 1'b0;
        end

        // Outputs are registered from the next state so they line up with it.
        opcode_d = (state_d == S_EXEC) ? ir_d[15:12] : 4'b0000;
        rre_d    = (state_d == S_FETCH);
        busy_d   = (state_d != S_IDLE) && (state_d != S_HALT);
        halted_d = (state_d == S_HALT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            ir_q       <= '0;
            step_req_q <= 1'b0;
            opcode_q   <= 4'b0000;
            rre_q      <= 1'b0;
            busy_q     <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            step_req_q <= step_req_d;
            opcode_q   <= opcode_d;
            rre_q      <= rre_d;
            busy_q     <= busy_d;
            halted_q   <= halted_d;
        end
    end

`ifdef SEQ_WATCHDOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            wdt_q   <= wdt_d;
            fault_q <= fault_d;
        end
    end
    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    assign rom_address     = pc_q;
    assign rom_read_enable = rre_q;
    assign opcode          = opcode_q;
    assign dest            = ir_q[11:6];
    assign src             = ir_q[5:0];
    assign pc              = pc_q;
    assign busy            = busy_q;
    assign halted          = halted_q;

endmodule
